// File: rtl/edge_capture_fifo_pkg.sv
// Shared widths and the default-sized entry layout for edge_capture_fifo.
// Optional timestamp field: EDGE_CAPTURE_FIFO_TIMESTAMP_EN.
package edge_capture_pkg;

   localparam int DEF_N_SIG  = 4;
   localparam int DEF_DATA_W = 256;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_TS_W   = 32;

   localparam int PTR_W = $clog2(DEF_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   // Occupancy must represent DEPTH itself, hence one bit beyond the pointer.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic [DEF_N_SIG-1:0]  rise;
      logic [DEF_N_SIG-1:0]  fall;
      logic [DEF_DATA_W-1:0] data;
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
      logic [DEF_TS_W-1:0]   ts;
`endif
   } entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Register-array FIFO with first-word-fall-through head; head reads 0 while empty.
// A write into a full FIFO succeeds when a read happens in the same cycle.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   assign empty = (level == '0);
   assign full  = (level == (PTR_W+1)'(DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clock) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_wr, do_rd})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/edge_capture_fifo.sv
// Per-strobe rise/fall detection feeding a FWFT FIFO, with event/drop statistics.
// Define EDGE_CAPTURE_FIFO_TIMESTAMP_EN to store a cycle timestamp per entry (out_ts).
module edge_capture_fifo
   import edge_capture_pkg::*;
#(
   parameter int N_SIG  = DEF_N_SIG,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TS_W   = DEF_TS_W
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_SIG-1:0]         sig_in,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [N_SIG-1:0]         out_rise,
   output logic [N_SIG-1:0]         out_fall,
   output logic [DATA_W-1:0]        out_data,
   output logic [CNT_W-1:0]         event_cnt,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow,
   output logic [lvl_w(DEPTH)-1:0]  level
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
   ,output logic [TS_W-1:0]         out_ts
`endif
);

   typedef struct packed {
      logic [N_SIG-1:0]  rise;
      logic [N_SIG-1:0]  fall;
      logic [DATA_W-1:0] data;
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
      logic [TS_W-1:0]   ts;
`endif
   } cap_entry_t;

   logic [N_SIG-1:0] prev_sig, rise, fall;
   logic             push_req, pop, accept, drop;
   logic             full, empty;
   cap_entry_t       wr_entry, head;

   assign rise     = sig_in & ~prev_sig;
   assign fall     = ~sig_in & prev_sig;
   assign push_req = |(rise | fall);
   assign out_valid = ~empty;
   assign pop      = out_valid & out_ready;
   // A pop in the same cycle frees the slot a full FIFO needs.
   assign accept   = push_req & (~full | pop);
   assign drop     = push_req & ~accept;

`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) ts_cnt <= '0;
      else        ts_cnt <= ts_cnt + TS_W'(1);
   end

   assign wr_entry = '{rise: rise, fall: fall, data: data_in, ts: ts_cnt};
   assign out_ts   = head.ts;
`else
   assign wr_entry = '{rise: rise, fall: fall, data: data_in};
`endif

   sync_fifo_fwft #(
      .WIDTH ($bits(cap_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (accept),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign out_rise = head.rise;
   assign out_fall = head.fall;
   assign out_data = head.data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_sig  <= '0;
         event_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         prev_sig <= sig_in;
         if (accept) event_cnt <= event_cnt + CNT_W'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_edge_capture_fifo.sv
// Directed self-checking bench for edge_capture_fifo (default 4 strobes, 256-bit data, depth 8).
module tb_edge_capture_fifo;

   localparam int N_SIG = 4, DATA_W = 256, DEPTH = 8, CNT_W = 16, TS_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [N_SIG-1:0]  sig_in = '0;
   logic [DATA_W-1:0] data_in = '0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [N_SIG-1:0]  out_rise, out_fall;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  event_cnt, drop_cnt;
   logic              overflow;
   logic [3:0]        level;
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
   logic [TS_W-1:0]   out_ts;
`endif

   int checks = 0;
   int errors = 0;

   edge_capture_fifo #(.N_SIG(N_SIG), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .clock(clock), .reset(reset), .sig_in(sig_in), .data_in(data_in), .out_ready(out_ready),
      .out_valid(out_valid), .out_rise(out_rise), .out_fall(out_fall), .out_data(out_data),
      .event_cnt(event_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .level(level)
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
      , .out_ts(out_ts)
`endif
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; sig_in = 4'b0001; data_in = 256'hA5; out_ready = 1'b0;
      repeat (3) step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
      checks++; if (event_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL reset_stats got ev=%0d dr=%0d ov=%0b exp 0/0/0", event_cnt, drop_cnt, overflow); end
      checks++; if (out_data !== 256'd0 || out_rise !== 4'd0 || out_fall !== 4'd0) begin
         errors++; $display("FAIL reset_head got d=%0h r=%b f=%b exp zeros", out_data, out_rise, out_fall); end
      reset = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", out_valid); end
      checks++; if (out_rise !== 4'b0001 || out_fall !== 4'b0000) begin
         errors++; $display("FAIL first_masks got r=%b f=%b exp r=0001 f=0000", out_rise, out_fall); end
      checks++; if (out_data !== 256'hA5) begin errors++; $display("FAIL first_data got %0h exp a5", out_data); end
      checks++; if (event_cnt !== 16'd1) begin errors++; $display("FAIL first_event got %0d exp 1", event_cnt); end
      // Head must hold while not ready.
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 256'hA5 || level !== 4'd1) begin
         errors++; $display("FAIL hold_head got v=%0b d=%0h l=%0d exp 1/a5/1", out_valid, out_data, level); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
         errors++; $display("FAIL first_pop got v=%0b l=%0d exp 0/0", out_valid, level); end
   endtask

   task automatic test_toggle();
      logic [3:0] seq [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sig_in = seq[k]; data_in = 256'h10 + 256'(k);
         step();
         checks++; if (out_valid !== 1'b1 || level !== 4'd1) begin
            errors++; $display("FAIL toggle_lvl%0d got v=%0b l=%0d exp 1/1", k, out_valid, level); end
         checks++; if (out_rise !== ((k % 2) ? 4'b0001 : 4'b0000) || out_fall !== ((k % 2) ? 4'b0000 : 4'b0001)
                       || out_data !== 256'h10 + 256'(k)) begin
            errors++; $display("FAIL toggle_entry%0d got r=%b f=%b d=%0h", k, out_rise, out_fall, out_data); end
      end
      step();
      checks++; if (event_cnt !== 16'd5 || level !== 4'd0) begin
         errors++; $display("FAIL toggle_end got ev=%0d l=%0d exp 5/0", event_cnt, level); end
   endtask

   task automatic test_same_cycle();
      out_ready = 1'b0;
      sig_in = 4'b0011; data_in = 256'h20; step();
      sig_in = 4'b1100; data_in = 256'h21; step();
      checks++; if (level !== 4'd2 || event_cnt !== 16'd7) begin
         errors++; $display("FAIL same_level got l=%0d ev=%0d exp 2/7", level, event_cnt); end
      out_ready = 1'b1; step();
      checks++; if (out_rise !== 4'b1100 || out_fall !== 4'b0011 || out_data !== 256'h21) begin
         errors++; $display("FAIL same_entry got r=%b f=%b d=%0h exp 1100/0011/21", out_rise, out_fall, out_data); end
      step();
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL same_drain got %0d exp 0", level); end
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         sig_in = (k % 2) ? 4'b1100 : 4'b1101; data_in = 256'h100 + 256'(k);
         step();
      end
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
      checks++; if (event_cnt !== 16'd15) begin errors++; $display("FAIL ovf_event got %0d exp 15", event_cnt); end
      checks++; if (drop_cnt !== 16'd2 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_drop got dr=%0d ov=%0b exp 2/1", drop_cnt, overflow); end
      checks++; if (out_data !== 256'h100 || out_rise !== 4'b0001) begin
         errors++; $display("FAIL ovf_head got d=%0h r=%b exp 100/0001", out_data, out_rise); end
   endtask

   task automatic test_full_pop();
      out_ready = 1'b1; sig_in = 4'b1101; data_in = 256'h10A;
      step();
      checks++; if (level !== 4'd8) begin errors++; $display("FAIL fullpop_level got %0d exp 8", level); end
      checks++; if (drop_cnt !== 16'd2 || event_cnt !== 16'd16) begin
         errors++; $display("FAIL fullpop_stats got dr=%0d ev=%0d exp 2/16", drop_cnt, event_cnt); end
   endtask

   task automatic test_drain();
      logic [DATA_W-1:0] exp_d;
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         exp_d = (k == 8) ? 256'h10A : 256'h100 + 256'(k);
         checks++; if (out_valid !== 1'b1 || out_data !== exp_d || out_rise !== ((k % 2) ? 4'b0000 : 4'b0001)) begin
            errors++; $display("FAIL drain%0d got v=%0b d=%0h r=%b exp d=%0h", k, out_valid, out_data, out_rise, exp_d); end
         step();
      end
      checks++; if (level !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
         errors++; $display("FAIL drain_end got l=%0d v=%0b ov=%0b exp 0/0/1", level, out_valid, overflow); end
      // Ready while empty must not disturb anything.
      step();
      checks++; if (level !== 4'd0 || event_cnt !== 16'd16) begin
         errors++; $display("FAIL empty_ready got l=%0d ev=%0d exp 0/16", level, event_cnt); end
   endtask

   task automatic test_reset_midop();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sig_in = (k % 2) ? 4'b1101 : 4'b1100; data_in = 256'h200 + 256'(k);
         step();
      end
      checks++; if (level !== 4'd5) begin errors++; $display("FAIL mid_level got %0d exp 5", level); end
      reset = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin
         errors++; $display("FAIL mid_async got v=%0b l=%0d exp 0/0", out_valid, level); end
      checks++; if (event_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin
         errors++; $display("FAIL mid_stats got ev=%0d dr=%0d ov=%0b exp 0/0/0", event_cnt, drop_cnt, overflow); end
      sig_in = 4'b0000;
      step(); step();
      reset = 1'b1;
      repeat (3) step();
      checks++; if (level !== 4'd0 || event_cnt !== 16'd0) begin
         errors++; $display("FAIL post_quiet got l=%0d ev=%0d exp 0/0", level, event_cnt); end
      sig_in = 4'b0001; data_in = 256'h3C;
      step();
      checks++; if (out_valid !== 1'b1 || out_rise !== 4'b0001 || out_data !== 256'h3C || event_cnt !== 16'd1) begin
         errors++; $display("FAIL post_edge got v=%0b r=%b d=%0h ev=%0d", out_valid, out_rise, out_data, event_cnt); end
`ifdef EDGE_CAPTURE_FIFO_TIMESTAMP_EN
      checks++; if (out_ts !== 32'd3) begin errors++; $display("FAIL post_ts got %0d exp 3", out_ts); end
`endif
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_same_cycle();
      test_overflow();
      test_full_pop();
      test_drain();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
